mvu_pe_acc: RTL

Per-PE accumulator stage that sits directly downstream of the SIMD adder tree in each processing element of the Matrix-Vector-Multiplication Unit. It consumes one adder-tree partial sum per accepted beat and accumulates SF beats, one per synapse fold, into a wider register. It then presents the completed dot product on a one-deep registered output with a valid/ready handshake. Backpressure from the output propagates upstream through in_rdy.

---
 rtl/mvu_pe_acc.sv | 70 +++++++
 1 files changed

// File: rtl/mvu_pe_acc.sv
// Per-PE accumulator behind the SIMD adder tree: sums SF signed partial sums per
// output and presents the dot product on a one-deep registered valid/ready output.
module mvu_pe_acc #(
   parameter int TI = 16,
   parameter int TO = 24,
   parameter int SF = 4
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic [TI-1:0] in_add,
   input  logic          in_v,
   output logic          in_rdy,
   output logic [TO-1:0] out_acc,
   output logic          out_v,
   input  logic          out_rdy
);

   // a 1-bit counter is kept for SF == 1 so the compare below still elaborates
   localparam int CW = (SF > 1) ? $clog2(SF) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SF - 1);

   logic [CW-1:0] cnt;
   logic [TO-1:0] acc;
   logic [TO-1:0] ext;
   logic [TO-1:0] sum;
   logic          accept;
   logic          last;

   generate
      if (TO > TI) begin : g_sext
         assign ext = {{(TO - TI){in_add[TI-1]}}, in_add};
      end else begin : g_noext
         assign ext = in_add;
      end
   endgenerate

   assign in_rdy = !out_v || out_rdy;
   assign accept = in_v && in_rdy;
   assign last   = (cnt == CNT_LAST);
   // acc is cleared on every last beat, so with SF == 1 it is always zero here
   assign sum    = acc + ext;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnt <= '0;
         acc <= '0;
      end else if (accept) begin
         if (last) begin
            cnt <= '0;
            acc <= '0;
         end else begin
            cnt <= cnt + CW'(1);
            acc <= sum;
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         out_acc <= '0;
         out_v   <= 1'b0;
      end else if (accept && last) begin
         out_acc <= sum;
         out_v   <= 1'b1;
      end else if (out_v && out_rdy) begin
         out_v   <= 1'b0;
      end
   end

endmodule
